// File: rtl/page_register_bank.sv
// Multi-channel CPU-addressed bank page register with auto-step, wrap limit and readback.
// Optional build macro PAGE_WRAP_IRQ_EN adds sticky per-channel wrap flags and the nIRQ output.
module page_register_bank #(
    parameter int PAGE_W = 3,
    parameter int NUM_CH = 2,
    parameter int DATA_W = 8
) (
    input  logic                       CLK,
    input  logic                       nRESET,
    input  logic                       nCS,
    input  logic                       nRD,
    input  logic                       nWR,
    input  logic [3:0]                 ADDR,
    input  logic [DATA_W-1:0]          DIN,
    output logic [DATA_W-1:0]          DOUT,
    output logic                       DOE,
    output logic [NUM_CH*PAGE_W-1:0]   PAGE,
    output logic                       nIRQ
);

    localparam logic [1:0] REG_PAGE  = 2'd0;
    localparam logic [1:0] REG_STEP  = 2'd1;
    localparam logic [1:0] REG_LIMIT = 2'd2;
    localparam logic [1:0] REG_CTRL  = 2'd3;

    // Bus synchroniser stages
    logic              ncs_s1_q, ncs_s2_q;
    logic              nrd_s1_q, nrd_s2_q;
    logic              nwr_s1_q, nwr_s2_q;
    logic [3:0]        addr_s1_q, addr_s2_q;
    logic [DATA_W-1:0] din_s1_q, din_s2_q;

    // Captured access event, applied one cycle after detection
    logic              ev_q;
    logic              ev_wr_q;
    logic [3:0]        ev_addr_q;
    logic [DATA_W-1:0] ev_din_q;

    logic strb_s1, strb_s2, ev_det;

    // Per-channel state
    logic [PAGE_W-1:0] page_q  [NUM_CH];
    logic [PAGE_W-1:0] page_d  [NUM_CH];
    logic [PAGE_W-1:0] limit_q [NUM_CH];
    logic [PAGE_W-1:0] limit_d [NUM_CH];
    logic [NUM_CH-1:0] dir_q, dir_d;
    logic [NUM_CH-1:0] step_en_q, step_en_d;
`ifdef PAGE_WRAP_IRQ_EN
    logic [NUM_CH-1:0] irq_en_q, irq_en_d;
    logic [NUM_CH-1:0] wrap_q, wrap_d;
    logic [NUM_CH-1:0] wrap_set, wrap_clr;
`endif

    logic [DATA_W-1:0] dout_v;
    logic              unused_bits;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            ncs_s1_q  <= 1'b1;
            ncs_s2_q  <= 1'b1;
            nrd_s1_q  <= 1'b1;
            nrd_s2_q  <= 1'b1;
            nwr_s1_q  <= 1'b1;
            nwr_s2_q  <= 1'b1;
            addr_s1_q <= '0;
            addr_s2_q <= '0;
            din_s1_q  <= '0;
            din_s2_q  <= '0;
            ev_q      <= 1'b0;
            ev_wr_q   <= 1'b0;
            ev_addr_q <= '0;
            ev_din_q  <= '0;
        end else begin
            ncs_s1_q  <= nCS;
            ncs_s2_q  <= ncs_s1_q;
            nrd_s1_q  <= nRD;
            nrd_s2_q  <= nrd_s1_q;
            nwr_s1_q  <= nWR;
            nwr_s2_q  <= nwr_s1_q;
            addr_s1_q <= ADDR;
            addr_s2_q <= addr_s1_q;
            din_s1_q  <= DIN;
            din_s2_q  <= din_s1_q;
            ev_q      <= ev_det;
            ev_wr_q   <= ~nwr_s2_q;
            ev_addr_q <= addr_s2_q;
            ev_din_q  <= din_s2_q;
        end
    end

    // Either strobe low makes an access; it completes when both are high again.
    // If nWR was low at that point the access is a write, even if nRD was low too.
    assign strb_s1 = ~nrd_s1_q | ~nwr_s1_q;
    assign strb_s2 = ~nrd_s2_q | ~nwr_s2_q;
    assign ev_det  = strb_s2 & ~strb_s1 & ~ncs_s2_q;

    always_comb begin
        page_d    = page_q;
        limit_d   = limit_q;
        dir_d     = dir_q;
        step_en_d = step_en_q;
`ifdef PAGE_WRAP_IRQ_EN
        irq_en_d  = irq_en_q;
        wrap_set  = '0;
        wrap_clr  = '0;
`endif
        for (int c = 0; c < NUM_CH; c++) begin
            if (ev_q && (ev_addr_q[3:2] == 2'(c))) begin
                case (ev_addr_q[1:0])
                    REG_PAGE: begin
                        if (ev_wr_q) page_d[c] = ev_din_q[PAGE_W-1:0];
                    end
                    REG_STEP: begin
                        if (step_en_q[c]) begin
                            if (!dir_q[c]) begin
                                if (page_q[c] >= limit_q[c]) begin
                                    page_d[c] = '0;
`ifdef PAGE_WRAP_IRQ_EN
                                    wrap_set[c] = 1'b1;
`endif
                                end else begin
                                    page_d[c] = page_q[c] + PAGE_W'(1);
                                end
                            end else begin
                                if (page_q[c] == '0) begin
                                    page_d[c] = limit_q[c];
`ifdef PAGE_WRAP_IRQ_EN
                                    wrap_set[c] = 1'b1;
`endif
                                end else if (page_q[c] > limit_q[c]) begin
                                    page_d[c] = limit_q[c];
                                end else begin
                                    page_d[c] = page_q[c] - PAGE_W'(1);
                                end
                            end
                        end
                    end
                    REG_LIMIT: begin
                        if (ev_wr_q) limit_d[c] = ev_din_q[PAGE_W-1:0];
                    end
                    REG_CTRL: begin
                        if (ev_wr_q) begin
                            dir_d[c]     = ev_din_q[0];
                            step_en_d[c] = ev_din_q[1];
`ifdef PAGE_WRAP_IRQ_EN
                            irq_en_d[c]  = ev_din_q[2];
                            wrap_clr[c]  = ev_din_q[3];
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
`ifdef PAGE_WRAP_IRQ_EN
        // A wrap in the same cycle as a clear keeps the flag set
        wrap_d = (wrap_q & ~wrap_clr) | wrap_set;
`endif
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            for (int c = 0; c < NUM_CH; c++) begin
                page_q[c]  <= '0;
                limit_q[c] <= '1;
            end
            dir_q     <= '0;
            step_en_q <= '1;
`ifdef PAGE_WRAP_IRQ_EN
            irq_en_q  <= '0;
            wrap_q    <= '0;
`endif
        end else begin
            page_q    <= page_d;
            limit_q   <= limit_d;
            dir_q     <= dir_d;
            step_en_q <= step_en_d;
`ifdef PAGE_WRAP_IRQ_EN
            irq_en_q  <= irq_en_d;
            wrap_q    <= wrap_d;
`endif
        end
    end

    // Readback decodes the raw bus address so data is valid throughout the strobe
    always_comb begin
        dout_v = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ADDR[3:2] == 2'(c)) begin
                case (ADDR[1:0])
                    REG_PAGE, REG_STEP: dout_v[PAGE_W-1:0] = page_q[c];
                    REG_LIMIT:          dout_v[PAGE_W-1:0] = limit_q[c];
                    REG_CTRL: begin
                        dout_v[0] = dir_q[c];
                        dout_v[1] = step_en_q[c];
`ifdef PAGE_WRAP_IRQ_EN
                        dout_v[2] = irq_en_q[c];
                        dout_v[3] = wrap_q[c];
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    assign DOE  = nRESET & ~nCS & ~nRD;
    assign DOUT = DOE ? dout_v : '0;

    always_comb begin
        PAGE = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            PAGE[c*PAGE_W +: PAGE_W] = page_q[c];
        end
    end

`ifdef PAGE_WRAP_IRQ_EN
    assign nIRQ = ~|(wrap_q & irq_en_q);
`else
    assign nIRQ = 1'b1;
`endif

    assign unused_bits = ^ev_din_q;

endmodule

// File: tb/tb_page_register_bank.sv
// Directed table-driven bench for page_register_bank (default parameters, PAGE_W=3, NUM_CH=2).
module tb_page_register_bank;

    logic       CLK = 1'b0;
    logic       nRESET;
    logic       nCS, nRD, nWR;
    logic [3:0] ADDR;
    logic [7:0] DIN;
    logic [7:0] DOUT;
    logic       DOE;
    logic [5:0] PAGE;
    logic       nIRQ;

    int total = 0;
    int bad   = 0;

`ifdef PAGE_WRAP_IRQ_EN
    localparam logic [7:0] CTRL1_RD   = 8'h07;
    localparam logic [7:0] CTRL1_WRAP = 8'h0F;
    localparam bit         IRQ_WRAP   = 1'b0;
`else
    localparam logic [7:0] CTRL1_RD   = 8'h03;
    localparam logic [7:0] CTRL1_WRAP = 8'h03;
    localparam bit         IRQ_WRAP   = 1'b1;
`endif

    page_register_bank #(.PAGE_W(3), .NUM_CH(2), .DATA_W(8)) dut (
        .CLK(CLK), .nRESET(nRESET), .nCS(nCS), .nRD(nRD), .nWR(nWR),
        .ADDR(ADDR), .DIN(DIN), .DOUT(DOUT), .DOE(DOE), .PAGE(PAGE), .nIRQ(nIRQ)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] din;
        bit         rd;
        bit         wr;
        bit         chk;
        logic [7:0] exp_dout;
        logic [5:0] exp_page;
        bit         exp_nirq;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [3:0] a, logic [7:0] d, bit rd, bit wr, bit chk,
                                logic [7:0] ed, logic [5:0] ep, bit ei);
        vec_t v;
        v.addr = a; v.din = d; v.rd = rd; v.wr = wr; v.chk = chk;
        v.exp_dout = ed; v.exp_page = ep; v.exp_nirq = ei;
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic bus_access(input logic [3:0] a, input logic [7:0] d, input bit rd,
                              input bit wr, output logic [7:0] q, output logic oe);
        ADDR = a; DIN = d; nCS = 1'b0;
        tick(1);
        nRD = !rd; nWR = !wr;
        tick(2);
        q  = DOUT;
        oe = DOE;
        nRD = 1'b1; nWR = 1'b1;
        tick(3);
        nCS = 1'b1;
        tick(2);
    endtask

    initial begin
        logic [7:0] q;
        logic       oe;

        nRESET = 1'b0; nCS = 1'b1; nRD = 1'b1; nWR = 1'b1; ADDR = '0; DIN = '0;
        tick(3);
        check("reset_page", PAGE, 6'h00);
        check("reset_doe",  DOE,  1'b0);
        check("reset_nirq", nIRQ, 1'b1);
        check("reset_dout", DOUT, 8'h00);
        nRESET = 1'b1;
        tick(2);

        // Page write latency: lands on the third clock after nWR rises
        ADDR = 4'h0; DIN = 8'h05; nCS = 1'b0;
        tick(1);
        nWR = 1'b0;
        tick(2);
        nWR = 1'b1;
        tick(2);
        check("write_early", PAGE, 6'h00);
        tick(1);
        check("write_land", PAGE, 6'h05);
        nCS = 1'b1;
        tick(2);

        tbl.push_back(mk(4'h2, 8'h00, 1, 0, 1, 8'h07, 6'h05, 1));        // ch0 LIMIT reset
        tbl.push_back(mk(4'h3, 8'h00, 1, 0, 1, 8'h02, 6'h05, 1));        // ch0 CTRL reset
        tbl.push_back(mk(4'h7, 8'h00, 1, 0, 1, 8'h02, 6'h05, 1));        // ch1 CTRL reset
        tbl.push_back(mk(4'h2, 8'h05, 0, 1, 0, 8'h00, 6'h05, 1));        // ch0 LIMIT=5
        tbl.push_back(mk(4'h0, 8'h04, 0, 1, 0, 8'h00, 6'h04, 1));        // ch0 PAGE=4
        tbl.push_back(mk(4'h1, 8'h00, 1, 0, 1, 8'h04, 6'h05, 1));        // step read 4
        tbl.push_back(mk(4'h1, 8'h00, 1, 0, 1, 8'h05, 6'h00, 1));        // step read 5, wrap
        tbl.push_back(mk(4'h1, 8'h00, 1, 0, 1, 8'h00, 6'h01, 1));        // step read 0
        tbl.push_back(mk(4'h7, 8'h07, 0, 1, 0, 8'h00, 6'h01, 1));        // ch1 CTRL=7
        tbl.push_back(mk(4'h7, 8'h00, 1, 0, 1, CTRL1_RD, 6'h01, 1));
        tbl.push_back(mk(4'h4, 8'h00, 0, 1, 0, 8'h00, 6'h01, 1));        // ch1 PAGE=0
        tbl.push_back(mk(4'h5, 8'hAA, 0, 1, 0, 8'h00, 6'h39, IRQ_WRAP)); // down wrap to 7
        tbl.push_back(mk(4'h7, 8'h00, 1, 0, 1, CTRL1_WRAP, 6'h39, IRQ_WRAP));
        tbl.push_back(mk(4'h7, 8'h0F, 0, 1, 0, 8'h00, 6'h39, 1));        // clear flag
        tbl.push_back(mk(4'h5, 8'h00, 1, 0, 1, 8'h07, 6'h31, 1));        // down 7 -> 6
        tbl.push_back(mk(4'hB, 8'h00, 1, 0, 1, 8'h00, 6'h31, 1));        // ch2 absent
        tbl.push_back(mk(4'h8, 8'h03, 0, 1, 0, 8'h00, 6'h31, 1));        // ch2 write ignored
        tbl.push_back(mk(4'h3, 8'h00, 0, 1, 0, 8'h00, 6'h31, 1));        // ch0 CTRL=0
        tbl.push_back(mk(4'h1, 8'h00, 0, 1, 0, 8'h00, 6'h31, 1));        // step disabled
        tbl.push_back(mk(4'h3, 8'h00, 1, 0, 1, 8'h00, 6'h31, 1));
        tbl.push_back(mk(4'h3, 8'h02, 0, 1, 0, 8'h00, 6'h31, 1));        // ch0 up, step on
        tbl.push_back(mk(4'h0, 8'h07, 0, 1, 0, 8'h00, 6'h37, 1));        // load above limit
        tbl.push_back(mk(4'h0, 8'h00, 1, 0, 1, 8'h07, 6'h37, 1));        // PAGE read no step
        tbl.push_back(mk(4'h1, 8'h00, 0, 1, 0, 8'h00, 6'h30, 1));        // 7 >= 5 -> 0
        tbl.push_back(mk(4'h2, 8'h00, 0, 1, 0, 8'h00, 6'h30, 1));        // LIMIT=0
        tbl.push_back(mk(4'h1, 8'h00, 0, 1, 0, 8'h00, 6'h30, 1));        // stays 0
        tbl.push_back(mk(4'h2, 8'h07, 0, 1, 0, 8'h00, 6'h30, 1));        // LIMIT=7
        tbl.push_back(mk(4'h0, 8'h03, 0, 1, 0, 8'h00, 6'h33, 1));        // PAGE=3

        foreach (tbl[i]) begin
            bus_access(tbl[i].addr, tbl[i].din, tbl[i].rd, tbl[i].wr, q, oe);
            if (tbl[i].chk) begin
                check($sformatf("dout[%0d]", i), q, tbl[i].exp_dout);
                check($sformatf("doe[%0d]", i), oe, 1'b1);
            end
            check($sformatf("page[%0d]", i), PAGE, tbl[i].exp_page);
            check($sformatf("nirq[%0d]", i), nIRQ, tbl[i].exp_nirq);
        end

        // nRD and nWR low together on STEP: one event, exactly +1
        bus_access(4'h1, 8'h00, 1, 1, q, oe);
        check("rdwr_step", PAGE, 6'h34);

        // Reset asserted mid-strobe, strobe rises after release
        ADDR = 4'h1; DIN = 8'h00; nCS = 1'b0;
        tick(1);
        nWR = 1'b0;
        tick(3);
        nRESET = 1'b0;
        #2;
        check("rst_mid_page", PAGE, 6'h00);
        tick(2);
        nRESET = 1'b1;
        tick(3);
        check("rst_hold_page", PAGE, 6'h00);
        nWR = 1'b1;
        tick(3);
        check("rst_one_event", PAGE, 6'h01);
        nCS = 1'b1;
        tick(4);
        check("rst_settled", PAGE, 6'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
